// File: rtl/pi_loop_sequencer.sv
// rtl/pi_loop_sequencer.sv - velocity PI loop scheduler: loop-rate tick, sample/update/settle/capture, duty publish
module pi_loop_sequencer #(
    parameter int PERIOD_W    = 16,
    parameter int PIPE_LAT    = 2,
    parameter int STALE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    input  logic                cfg_wr,
    input  logic [13:0]         cfg_kp,
    input  logic [13:0]         cfg_ki,
    input  logic [15:0]         cfg_desired,
    input  logic                meas_valid,
    input  logic [15:0]         meas_velocity,
    output logic                meas_ready,
    output logic [13:0]         kp,
    output logic [13:0]         ki,
    output logic [15:0]         desired_velocity,
    output logic [15:0]         actual_velocity,
    output logic                pi_enable,
    input  logic [9:0]          gain_in,
    output logic [9:0]          duty_gain,
    output logic                duty_valid,
    output logic                stale,
    output logic                overrun
);

    localparam int SW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int MW = $clog2(STALE_LIMIT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(PIPE_LAT - 1);
    localparam logic [MW-1:0] MISS_MAX    = MW'(STALE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SAMPLE, S_UPDATE, S_SETTLE, S_CAPTURE
    } state_t;

    state_t              state, state_next;
    logic [PERIOD_W-1:0] count;
    logic                tick;
    logic [SW-1:0]       settle_cnt;
    logic [MW-1:0]       miss_cnt;
    logic [13:0]         sh_kp, sh_ki;
    logic [15:0]         sh_desired;

    assign tick  = run && (count == '0);
    assign stale = (miss_cnt >= MISS_MAX);

    // Loop-rate down-counter; parked at the reload value whenever the loop is stopped.
    always_ff @(posedge clk) begin
        if (reset || !run || tick)
            count <= period;
        else
            count <= count - PERIOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!run) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_next = S_WAIT;
                S_WAIT:    if (tick) state_next = S_SAMPLE;
                S_SAMPLE:  state_next = S_UPDATE;
                S_UPDATE:  state_next = S_SETTLE;
                S_SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = S_CAPTURE;
                S_CAPTURE: state_next = S_WAIT;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        meas_ready = run && (state == S_SAMPLE);
        pi_enable  = (state == S_UPDATE);
    end

    always_ff @(posedge clk) begin
        if (reset || state != S_SETTLE)
            settle_cnt <= '0;
        else
            settle_cnt <= settle_cnt + SW'(1);
    end

    // Shadow copy happens with the old shadow value, so a same-cycle cfg_wr lands next loop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_kp            <= '0;
            sh_ki            <= '0;
            sh_desired       <= '0;
            kp               <= '0;
            ki               <= '0;
            desired_velocity <= '0;
            actual_velocity  <= '0;
            miss_cnt         <= '0;
            duty_gain        <= '0;
            duty_valid       <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (cfg_wr) begin
                sh_kp      <= cfg_kp;
                sh_ki      <= cfg_ki;
                sh_desired <= cfg_desired;
            end
            if (!run) begin
                duty_gain  <= '0;
                duty_valid <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                duty_valid <= (state == S_CAPTURE);
                if (state == S_SAMPLE) begin
                    kp               <= sh_kp;
                    ki               <= sh_ki;
                    desired_velocity <= sh_desired;
                    if (meas_valid) begin
                        actual_velocity <= meas_velocity;
                        miss_cnt        <= '0;
                    end else if (miss_cnt != MISS_MAX) begin
                        miss_cnt <= miss_cnt + MW'(1);
                    end
                end
                if (state == S_CAPTURE)
                    duty_gain <= stale ? '0 : gain_in;
                if (tick && state != S_WAIT)
                    overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// tb/tb_pi_loop_sequencer.sv - directed and random checks of pi_loop_sequencer against a timeline model
module tb_pi_loop_sequencer;

    localparam int PERIOD_W = 16;
    localparam int PIPE_LAT = 2;
    localparam int LIM      = 4;
    localparam int CAP_D    = 3 + PIPE_LAT;

    logic                clk = 1'b0;
    logic                reset, run, cfg_wr, meas_valid;
    logic [PERIOD_W-1:0] period;
    logic [13:0]         cfg_kp, cfg_ki, kp, ki;
    logic [15:0]         cfg_desired, meas_velocity, desired_velocity, actual_velocity;
    logic                meas_ready, pi_enable, duty_valid, stale, overrun;
    logic [9:0]          gain_in, duty_gain;

    pi_loop_sequencer #(.PERIOD_W(PERIOD_W), .PIPE_LAT(PIPE_LAT), .STALE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .run(run), .period(period),
        .cfg_wr(cfg_wr), .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_desired(cfg_desired),
        .meas_valid(meas_valid), .meas_velocity(meas_velocity), .meas_ready(meas_ready),
        .kp(kp), .ki(ki), .desired_velocity(desired_velocity), .actual_velocity(actual_velocity),
        .pi_enable(pi_enable), .gain_in(gain_in), .duty_gain(duty_gain), .duty_valid(duty_valid),
        .stale(stale), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit checking = 0;
    bit hold_vel = 0;
    bit last_pi;
    int n;

    // Model: loop progress is the cycle offset from the accepted tick.
    int m_c = 0, m_loop = -1, m_cnt = 0, m_miss = 0;
    bit m_active = 0, m_dv = 0, m_ovr = 0;
    int m_kp = 0, m_ki = 0, m_des = 0, m_act = 0, m_dg = 0;
    int s_kp = 0, s_ki = 0, s_des = 0;

    function automatic int phase();
        return (m_active && m_loop >= 0) ? (m_c - m_loop) : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  d;
        bit  tk;
        if (reset) begin
            m_loop = -1; m_active = 0; m_cnt = int'(period); m_miss = 0;
            m_dv = 0; m_ovr = 0; m_dg = 0;
            m_kp = 0; m_ki = 0; m_des = 0; m_act = 0;
            s_kp = 0; s_ki = 0; s_des = 0;
        end else begin
            if (!run) begin
                m_active = 0; m_loop = -1; m_dg = 0; m_dv = 0; m_ovr = 0;
                m_cnt = int'(period);
            end else begin
                d  = phase();
                tk = (m_cnt == 0);
                m_dv = (d == CAP_D);
                if (d == 1) begin
                    m_kp = s_kp; m_ki = s_ki; m_des = s_des;
                    if (meas_valid) begin
                        m_act  = int'(meas_velocity);
                        m_miss = 0;
                    end else if (m_miss < LIM) begin
                        m_miss++;
                    end
                end
                if (d == CAP_D)
                    m_dg = (m_miss >= LIM) ? 0 : int'(gain_in);
                if (tk) begin
                    if (m_active && !(d >= 1 && d <= CAP_D))
                        m_loop = m_c;
                    else
                        m_ovr = 1;
                    m_cnt = int'(period);
                end else begin
                    m_cnt--;
                end
                m_active = 1;
            end
            if (cfg_wr) begin
                s_kp = int'(cfg_kp); s_ki = int'(cfg_ki); s_des = int'(cfg_desired);
            end
        end
        m_c++;
    endtask

    task automatic cycle();
        int d;
        gain_in = 10'($urandom);
        if (!hold_vel) meas_velocity = 16'($urandom);
        #1;
        if (checking) begin
            d = phase();
            chk("meas_ready", meas_ready, (m_active && run && d == 1));
            chk("pi_enable", pi_enable, (m_active && d == 2));
            chk("kp", kp, m_kp);
            chk("ki", ki, m_ki);
            chk("desired", desired_velocity, m_des);
            chk("actual", actual_velocity, m_act);
            chk("duty_gain", duty_gain, m_dg);
            chk("duty_valid", duty_valid, m_dv);
            chk("stale", stale, (m_miss >= LIM));
            chk("overrun", overrun, m_ovr);
        end
        last_pi = pi_enable;
        model_step();
        @(negedge clk);
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic wait_phase(input int target, input string tag);
        for (int k = 0; k < 40 && phase() != target; k++) cycle();
        chk(tag, (phase() == target), 1);
    endtask

    initial begin
        reset = 1; run = 0; period = 16'd9; cfg_wr = 0; cfg_kp = 0; cfg_ki = 0;
        cfg_desired = 0; meas_valid = 1; meas_velocity = 0; gain_in = 0;
        @(negedge clk);
        cycle();
        checking = 1;
        cycle();
        reset = 0;

        // Basic loop, period 9, always-valid measurements.
        run = 1;
        run_cycles(40);

        // Double-buffered gains: a write in the SAMPLE cycle lands one loop later.
        cfg_wr = 1; cfg_kp = 14'd100; cfg_ki = 14'd7; cfg_desired = 16'd500;
        cycle();
        cfg_wr = 0;
        run_cycles(12);
        wait_phase(1, "reach_sample_a");
        cfg_wr = 1; cfg_kp = 14'd200;
        cycle();
        cfg_wr = 0;
        chk("kp_old_loop", kp, 100);
        run_cycles(10);
        chk("kp_new_loop", kp, 200);

        // Four missed samples -> stale, zero duty; one good sample recovers.
        meas_valid = 0;
        run_cycles(45);
        chk("stale_set", stale, 1);
        chk("stale_duty_zero", duty_gain, 0);
        meas_valid = 1; hold_vel = 1; meas_velocity = 16'd1234;
        run_cycles(12);
        chk("recover_actual", actual_velocity, 1234);
        chk("recover_stale", stale, 0);
        hold_vel = 0;

        // Too-short period -> sticky overrun, cleared by run=0.
        period = 16'd2;
        run_cycles(30);
        chk("overrun_set", overrun, 1);
        run_cycles(5);
        chk("overrun_sticky", overrun, 1);
        run = 0;
        cycle();
        chk("overrun_clear", overrun, 0);
        chk("idle_pi", pi_enable, 0);

        // Abort during SETTLE: no duty_valid, duty_gain cleared.
        period = 16'd9;
        run = 1;
        run_cycles(3);
        wait_phase(3, "reach_settle_a");
        run = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("abort_dv", duty_valid, 0);
            chk("abort_dg", duty_gain, 0);
        end
        run = 1;
        run_cycles(25);

        // Reset mid-SETTLE; first pi_enable period+3 cycles from the reset cycle.
        wait_phase(3, "reach_settle_b");
        reset = 1;
        cycle();
        reset = 0;
        for (n = 1; n < 40; n++) begin
            cycle();
            if (n == 1) begin
                chk("rst_kp", kp, 0);
                chk("rst_actual", actual_velocity, 0);
                chk("rst_dg", duty_gain, 0);
            end
            if (last_pi) break;
        end
        chk("first_pi_delay", n, 9 + 3);

        // Random traffic with alternating measurement-loss density.
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 200; i++) begin
                reset  = ($urandom_range(0, 299) == 0);
                run    = ($urandom_range(0, 49) != 0);
                if ($urandom_range(0, 99) == 0) period = 16'($urandom_range(0, 12));
                meas_valid = (blk % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                cfg_wr      = ($urandom_range(0, 7) == 0);
                cfg_kp      = 14'($urandom);
                cfg_ki      = 14'($urandom);
                cfg_desired = 16'($urandom);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
